// File: rtl/cci_rd_arbiter.sv
// cci_rd_arbiter: round-robin arbiter sharing the CCI-P c0 read-request channel and routing responses by mdata id
//    clk, spl_reset_n            : AFU clock, async active-low reset
//    req_valid/req_addr/req_tag  : per-requester read requests (packed, requester i in slice i)
//    req_ready                   : combinational one-hot grant
//    spl_tx_rd_almostfull        : c0 Tx backpressure
//    afu_tx_rd_valid/addr/mdata  : registered c0 Tx read request, mdata = {0, id, tag}
//    spl_rx_rd_valid/mdata/data  : c0 Rx read response
//    rsp_valid/rsp_tag/rsp_data  : registered one-hot routed response
//    idle, err                   : no reads in flight; sticky bad-response flag
module cci_rd_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 42,
   parameter int TAG_W   = 8,
   parameter int MAX_OUT = 32
) (
   input  logic                      clk,
   input  logic                      spl_reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      spl_tx_rd_almostfull,
   output logic                      afu_tx_rd_valid,
   output logic [ADDR_W-1:0]         afu_tx_rd_addr,
   output logic [15:0]               afu_tx_rd_mdata,
   input  logic                      spl_rx_rd_valid,
   input  logic [15:0]               spl_rx_rd_mdata,
   input  logic [511:0]              spl_rx_data,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [TAG_W-1:0]          rsp_tag,
   output logic [511:0]              rsp_data,
   output logic                      idle,
   output logic                      err
);
   localparam int ID_W = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0][7:0] cnt_q, cnt_d;
   logic [ID_W-1:0]         rr_q, rr_d, gnt_id, rx_id;
   logic [NUM_REQ-1:0]      elig, rsp_valid_q, rsp_valid_d;
   logic                    gnt_any, rx_ok;
   logic                    tx_valid_q, tx_valid_d, err_q, err_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [15:0]             mdata_q, mdata_d;
   logic [TAG_W-1:0]        tag_q, tag_d;
   logic [511:0]            data_q, data_d;
   assign rx_id = spl_rx_rd_mdata[TAG_W+ID_W-1:TAG_W];
   // Scan downward so the lowest offset from rr_q is the one left standing.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id = '0;
      rx_ok = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = req_valid[i] & ~spl_tx_rd_almostfull & (cnt_q[i] < 8'(MAX_OUT));
         if (rx_id == ID_W'(i) && cnt_q[i] != 8'd0) rx_ok = spl_rx_rd_valid;
      end
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (elig[(int'(rr_q) + k) % NUM_REQ]) begin
            gnt_any = 1'b1;
            gnt_id = ID_W'((int'(rr_q) + k) % NUM_REQ);
         end
   end
   assign req_ready = NUM_REQ'(gnt_any) << gnt_id;
   always_comb begin
      rr_d = gnt_any ? (gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1) : rr_q;
      tx_valid_d = gnt_any;
      addr_d = gnt_any ? req_addr[gnt_id*ADDR_W +: ADDR_W] : addr_q;
      mdata_d = mdata_q;
      if (gnt_any) begin
         mdata_d = '0;
         mdata_d[TAG_W+ID_W-1:TAG_W] = gnt_id;
         mdata_d[TAG_W-1:0] = req_tag[gnt_id*TAG_W +: TAG_W];
      end
      rsp_valid_d = rx_ok ? NUM_REQ'(1) << rx_id : '0;
      tag_d = rx_ok ? spl_rx_rd_mdata[TAG_W-1:0] : tag_q;
      data_d = rx_ok ? spl_rx_data : data_q;
      err_d = err_q | (spl_rx_rd_valid & ~rx_ok);
      // A grant and an accepted response to the same requester cancel out.
      for (int i = 0; i < NUM_REQ; i++)
         cnt_d[i] = cnt_q[i] + 8'(gnt_any && gnt_id == ID_W'(i)) - 8'(rx_ok && rx_id == ID_W'(i));
   end
   always_ff @(posedge clk or negedge spl_reset_n) begin
      if (!spl_reset_n) begin
         cnt_q <= '0;
         rr_q <= '0;
         tx_valid_q <= 1'b0;
         addr_q <= '0;
         mdata_q <= '0;
         rsp_valid_q <= '0;
         tag_q <= '0;
         data_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rr_q <= rr_d;
         tx_valid_q <= tx_valid_d;
         addr_q <= addr_d;
         mdata_q <= mdata_d;
         rsp_valid_q <= rsp_valid_d;
         tag_q <= tag_d;
         data_q <= data_d;
         err_q <= err_d;
      end
   end
   assign afu_tx_rd_valid = tx_valid_q;
   assign afu_tx_rd_addr = addr_q;
   assign afu_tx_rd_mdata = mdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_tag = tag_q;
   assign rsp_data = data_q;
   assign err = err_q;
   assign idle = (cnt_q == '0) && !tx_valid_q;
endmodule

// File: tb/tb_cci_rd_arbiter.sv
// tb_cci_rd_arbiter: randomized scoreboard bench for cci_rd_arbiter against a queue-based reference model
module tb_cci_rd_arbiter;
   localparam int N = 3, AW = 42, TW = 8, MO = 3, IW = 2;
   logic              clk = 1'b0;
   logic              spl_reset_n;
   logic [N-1:0]      req_valid, req_ready, rsp_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*TW-1:0]   req_tag;
   logic              spl_tx_rd_almostfull, afu_tx_rd_valid, spl_rx_rd_valid, idle, err;
   logic [AW-1:0]     afu_tx_rd_addr;
   logic [15:0]       afu_tx_rd_mdata, spl_rx_rd_mdata;
   logic [511:0]      spl_rx_data, rsp_data;
   logic [TW-1:0]     rsp_tag;
   int                total = 0, bad = 0;
   int                cnt [N];
   int                rr;
   bit                err_m, prev_tx, mon_on, all0;
   bit                pend [N];
   logic [AW-1:0]     addr_a [N];
   logic [TW-1:0]     tag_a [N];
   logic [AW+15:0]    tx_q [$];
   logic [IW+TW+511:0] rsp_q [$];
   logic [15:0]       out_q [$];
   logic [AW+15:0]    mt;
   logic [IW+TW+511:0] mr;

   always #5 clk = ~clk;

   cci_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TAG_W(TW), .MAX_OUT(MO)) dut (
      .clk(clk), .spl_reset_n(spl_reset_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
      .spl_tx_rd_almostfull(spl_tx_rd_almostfull),
      .afu_tx_rd_valid(afu_tx_rd_valid), .afu_tx_rd_addr(afu_tx_rd_addr), .afu_tx_rd_mdata(afu_tx_rd_mdata),
      .spl_rx_rd_valid(spl_rx_rd_valid), .spl_rx_rd_mdata(spl_rx_rd_mdata), .spl_rx_data(spl_rx_data),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
      .idle(idle), .err(err)
   );

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor: registered outputs are stable through the low phase; each expectation
   // pushed during cycle N must appear exactly at the following negedge.
   always @(negedge clk) if (mon_on) begin
      if (tx_q.size() > 0) begin
         mt = tx_q.pop_front();
         chk("tx_valid", 512'(afu_tx_rd_valid), 512'(1));
         chk("tx_addr", 512'(afu_tx_rd_addr), 512'(mt[AW+15:16]));
         chk("tx_mdata", 512'(afu_tx_rd_mdata), 512'(mt[15:0]));
      end else if (afu_tx_rd_valid) chk("tx_extra", 512'(afu_tx_rd_valid), 512'(0));
      if (rsp_q.size() > 0) begin
         mr = rsp_q.pop_front();
         chk("rsp_valid", 512'(rsp_valid), 512'(N'(1) << mr[IW+TW+511:TW+512]));
         chk("rsp_tag", 512'(rsp_tag), 512'(mr[TW+511:512]));
         chk("rsp_data", rsp_data, mr[511:0]);
      end else if (rsp_valid != '0) chk("rsp_extra", 512'(rsp_valid), 512'(0));
      all0 = 1'b1;
      for (int i = 0; i < N; i++) if (cnt[i] != 0) all0 = 1'b0;
      chk("err", 512'(err), 512'(err_m));
      chk("idle", 512'(idle), 512'(all0 && !prev_tx));
   end

   task automatic post(input int i, input logic [AW-1:0] a, input logic [TW-1:0] t);
      if (!pend[i]) begin
         pend[i] = 1'b1;
         addr_a[i] = a;
         tag_a[i] = t;
      end
   endtask

   function automatic logic [AW-1:0] ra();
      return AW'({$urandom(), $urandom()});
   endfunction

   // One cycle: drive at negedge, predict grant/response from the rules, wait for next negedge.
   // rm: 0 no response, 1 return a random outstanding read, 2 send md as given.
   task automatic step(input bit af, input int rm, input logic [15:0] md);
      int g, id, j;
      bit acc, rv;
      logic [511:0] d;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = pend[i];
         req_addr[i*AW +: AW] = addr_a[i];
         req_tag[i*TW +: TW] = tag_a[i];
      end
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
      rv = (rm == 2);
      if (rm == 1 && out_q.size() > 0) begin
         j = $urandom_range(out_q.size() - 1);
         md = out_q[j];
         out_q.delete(j);
         rv = 1'b1;
      end
      spl_tx_rd_almostfull = af;
      spl_rx_rd_valid = rv;
      spl_rx_rd_mdata = md;
      spl_rx_data = d;
      #1;
      g = -1;
      for (int k = 0; k < N; k++)
         if (g < 0 && pend[(rr + k) % N] && !af && cnt[(rr + k) % N] < MO) g = (rr + k) % N;
      chk("req_ready", 512'(req_ready), g < 0 ? 512'(0) : 512'(1) << g);
      id = int'(md[TW+IW-1:TW]);
      acc = rv && id < N;
      if (acc) acc = cnt[id] > 0;
      if (rv && !acc) err_m = 1'b1;
      if (acc) begin
         rsp_q.push_back({md[TW+IW-1:TW], md[TW-1:0], d});
         cnt[id]--;
      end
      if (g >= 0) begin
         tx_q.push_back({addr_a[g], 16'((g << TW) | int'(tag_a[g]))});
         out_q.push_back(16'((g << TW) | int'(tag_a[g])));
         cnt[g]++;
         rr = (g + 1) % N;
         pend[g] = 1'b0;
      end
      prev_tx = (g >= 0);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int c = 0; c < 60 && (out_q.size() > 0 || pend[0] || pend[1] || pend[2]); c++) step(1'b0, 1, 16'h0);
      step(1'b0, 0, 16'h0);
      step(1'b0, 0, 16'h0);
   endtask

   task automatic model_reset();
      tx_q.delete();
      rsp_q.delete();
      out_q.delete();
      rr = 0;
      err_m = 1'b0;
      prev_tx = 1'b0;
      for (int i = 0; i < N; i++) begin
         cnt[i] = 0;
         pend[i] = 1'b0;
      end
   endtask

   task automatic chk_reset();
      chk("rst_tx_valid", 512'(afu_tx_rd_valid), 512'(0));
      chk("rst_tx_addr", 512'(afu_tx_rd_addr), 512'(0));
      chk("rst_tx_mdata", 512'(afu_tx_rd_mdata), 512'(0));
      chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
      chk("rst_rsp_tag", 512'(rsp_tag), 512'(0));
      chk("rst_rsp_data", rsp_data, 512'(0));
      chk("rst_err", 512'(err), 512'(0));
      chk("rst_idle", 512'(idle), 512'(1));
   endtask

   initial begin
      spl_reset_n = 1'b0;
      req_valid = '0;
      req_addr = '0;
      req_tag = '0;
      spl_tx_rd_almostfull = 1'b0;
      spl_rx_rd_valid = 1'b0;
      spl_rx_rd_mdata = '0;
      spl_rx_data = '0;
      mon_on = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_reset();
      chk("rst_req_ready", 512'(req_ready), 512'(0));
      spl_reset_n = 1'b1;
      mon_on = 1'b1;
      // single request and its response
      post(0, AW'('h123), 8'h5A);
      repeat (3) step(1'b0, 0, 16'h0);
      step(1'b0, 1, 16'h0);
      repeat (2) step(1'b0, 0, 16'h0);
      // fairness with all requesters valid
      repeat (12) begin
         for (int i = 0; i < N; i++) post(i, ra(), TW'($urandom));
         step(1'b0, 1, 16'h0);
      end
      drain();
      // backpressure in cycles 3..6
      for (int c = 0; c < 10; c++) begin
         for (int i = 0; i < N; i++) post(i, ra(), TW'($urandom));
         step(c >= 3 && c <= 6, 1, 16'h0);
      end
      drain();
      // outstanding limit on requester 2
      repeat (6) begin
         post(2, ra(), TW'($urandom));
         step(1'b0, 0, 16'h0);
      end
      step(1'b0, 1, 16'h0);
      repeat (3) step(1'b0, 0, 16'h0);
      drain();
      // grant and response to requester 1 in the same cycle
      post(1, ra(), TW'($urandom));
      step(1'b0, 0, 16'h0);
      post(1, ra(), TW'($urandom));
      step(1'b0, 1, 16'h0);
      step(1'b0, 0, 16'h0);
      drain();
      // response to requester 0 with nothing outstanding
      step(1'b0, 2, 16'h0011);
      repeat (2) step(1'b0, 0, 16'h0);
      // randomized traffic
      repeat (400) begin
         int r;
         for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) post(i, ra(), TW'($urandom));
         r = $urandom_range(99);
         step($urandom_range(4) == 0, r < 55 ? 1 : (r < 58 ? 2 : 0), 16'($urandom_range(16'h3ff)));
      end
      // reset in the middle of traffic
      for (int i = 0; i < N; i++) post(i, ra(), TW'($urandom));
      step(1'b0, 0, 16'h0);
      step(1'b0, 1, 16'h0);
      #3;
      mon_on = 1'b0;
      spl_reset_n = 1'b0;
      #1;
      chk_reset();
      model_reset();
      @(negedge clk);
      spl_reset_n = 1'b1;
      mon_on = 1'b1;
      // out-of-range id after reset
      step(1'b0, 2, 16'h0300);
      repeat (2) step(1'b0, 0, 16'h0);
      post(1, ra(), TW'($urandom));
      post(0, ra(), TW'($urandom));
      step(1'b0, 0, 16'h0);
      drain();
      chk("tx_q_left", 512'(tx_q.size()), 512'(0));
      chk("rsp_q_left", 512'(rsp_q.size()), 512'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
